// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1:4 destination demux stage.
package demux_pkg;

  localparam int NPORTS = 4;
  localparam int SEL_W  = 2;

  function automatic logic [NPORTS-1:0] sel2onehot(input logic [SEL_W-1:0] sel);
    logic [NPORTS-1:0] r_oh;
    r_oh      = '0;
    r_oh[sel] = 1'b1;
    return r_oh;
  endfunction

endpackage

// File: rtl/demux1to4_32.sv
// Registered valid/ready 1:4 demux: steers each word to the consumer named by its select.
// Build option DEMUX_SKID_EN adds a skid entry so in_ready has no path from out_ready.
module demux1to4_32
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [NPORTS-1:0] out_valid,
  input  logic [NPORTS-1:0] out_ready,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic             r_started;
  logic             r_hv;
  logic [WIDTH-1:0] r_hd;
  logic [SEL_W-1:0] r_hs;
  logic [CNT_W-1:0] r_cnt;

  logic w_deliver;
  logic w_accept;
  logic w_in_ready;

  assign w_deliver = r_hv & (|(sel2onehot(r_hs) & out_ready));
  assign w_accept  = in_valid & w_in_ready;

  assign in_ready  = w_in_ready;
  assign out_data  = r_hd;
  assign out_valid = r_hv ? sel2onehot(r_hs) : '0;
  assign xfer_cnt  = r_cnt;

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_started <= 1'b0;
    else        r_started <= 1'b1;
  end

  // A delivery in a flush cycle still counts: the consumer already saw valid&ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= '0;
    else if (w_deliver) r_cnt <= r_cnt + CNT_W'(1);
  end

`ifdef DEMUX_SKID_EN
  logic             r_sv;
  logic [WIDTH-1:0] r_sd;
  logic [SEL_W-1:0] r_ss;

  assign w_in_ready = r_started & ~r_sv & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hv <= 1'b0;
      r_hd <= '0;
      r_hs <= '0;
      r_sv <= 1'b0;
      r_sd <= '0;
      r_ss <= '0;
    end else if (flush) begin
      r_hv <= 1'b0;
      r_sv <= 1'b0;
    end else if (w_deliver) begin
      if (r_sv) begin
        r_hd <= r_sd;
        r_hs <= r_ss;
        r_sv <= 1'b0;
      end else if (w_accept) begin
        r_hd <= in_data;
        r_hs <= in_sel;
      end else begin
        r_hv <= 1'b0;
      end
    end else if (w_accept) begin
      if (r_hv) begin
        r_sd <= in_data;
        r_ss <= in_sel;
        r_sv <= 1'b1;
      end else begin
        r_hd <= in_data;
        r_hs <= in_sel;
        r_hv <= 1'b1;
      end
    end
  end
`else
  assign w_in_ready = r_started & ~flush & (~r_hv | w_deliver);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hv <= 1'b0;
      r_hd <= '0;
      r_hs <= '0;
    end else if (flush) begin
      r_hv <= 1'b0;
    end else if (w_accept) begin
      r_hv <= 1'b1;
      r_hd <= in_data;
      r_hs <= in_sel;
    end else if (w_deliver) begin
      r_hv <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_demux1to4_32.sv
// Self-checking bench for demux1to4_32 against a queue-based reference model.
module tb_demux1to4_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  out_ready = '0;

  logic        in_ready, in_ready4;
  logic [31:0] out_data, out_data4;
  logic [3:0]  out_valid, out_valid4;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  demux1to4_32 #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  demux1to4_32 #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .xfer_cnt(xfer_cnt4)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of pending words, capacity 1 (base) or 2 (skid build).
  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
  } word_t;

  word_t       q[$];
  int unsigned m_cnt = 0;
  logic [31:0] m_last = '0;
  bit          m_started = 1'b0;

  function logic [3:0] m_valid();
    if (q.size() == 0) return 4'b0000;
    return 4'(2 ** int'(q[0].s));
  endfunction

  function bit m_deliver();
    return (q.size() > 0) && out_ready[q[0].s];
  endfunction

  function bit m_in_ready();
    if (!m_started || flush) return 1'b0;
`ifdef DEMUX_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || m_deliver();
`endif
  endfunction

  task automatic apply(input bit v, input logic [31:0] d, input logic [1:0] s,
                       input logic [3:0] r, input bit f);
    bit    acc, del;
    word_t w;
    @(negedge clk);
    in_valid = v; in_data = d; in_sel = s; out_ready = r; flush = f;
    #1;
    acc = in_valid && m_in_ready();
    del = m_deliver();
    w.d = d; w.s = s;
    @(posedge clk);
    if (del) m_cnt++;
    if (f) q.delete();
    else begin
      if (del) void'(q.pop_front());
      if (acc) q.push_back(w);
    end
    m_started = 1'b1;
    if (q.size() > 0) m_last = q[0].d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 4'hF; flush = 1'b0;
    #1;
    q.delete(); m_cnt = 0; m_last = '0; m_started = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0000", out_valid); end
    n_tests++; if (xfer_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_xfer_cnt got=%0d exp=0", xfer_cnt); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    release_reset();
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready_early got=%b exp=0", in_ready); end
    apply(1'b0, 32'h0, 2'd0, 4'hF, 1'b0);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_route();
    apply(1'b1, 32'hA5A5_0001, 2'd2, 4'hF, 1'b0);
    n_tests++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL route_valid got=%b exp=0100", out_valid); end
    n_tests++; if (out_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL route_data got=%h exp=a5a50001", out_data); end
    apply(1'b0, 32'h0, 2'd0, 4'hF, 1'b0);
    n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL route_valid_after got=%b exp=0000", out_valid); end
    n_tests++; if (xfer_cnt !== 16'd1) begin n_fail++; $display("FAIL route_cnt got=%0d exp=1", xfer_cnt); end
    n_tests++; if (out_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL route_data_hold got=%h exp=a5a50001", out_data); end
  endtask

  task automatic test_stall();
    apply(1'b1, 32'hB000_0000, 2'd3, 4'b0111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 32'hB000_0001, 2'd1, 4'b0111, 1'b0);
      n_tests++; if (out_valid !== 4'b1000) begin n_fail++; $display("FAIL stall_valid[%0d] got=%b exp=1000", i, out_valid); end
      n_tests++; if (out_data !== 32'hB000_0000) begin n_fail++; $display("FAIL stall_data[%0d] got=%h exp=b0000000", i, out_data); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", i, in_ready); end
    end
    apply(1'b0, 32'h0, 2'd0, 4'hF, 1'b0);
`ifdef DEMUX_SKID_EN
    n_tests++; if (out_valid !== 4'b0010) begin n_fail++; $display("FAIL stall_second_valid got=%b exp=0010", out_valid); end
    n_tests++; if (out_data !== 32'hB000_0001) begin n_fail++; $display("FAIL stall_second_data got=%h exp=b0000001", out_data); end
    apply(1'b0, 32'h0, 2'd0, 4'hF, 1'b0);
`endif
    n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL stall_drain_valid got=%b exp=0000", out_valid); end
    n_tests++; if (xfer_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=%0d", xfer_cnt, 16'(m_cnt)); end
  endtask

  task automatic test_stream();
    int unsigned start;
    logic [31:0] d;
    start = m_cnt;
    for (int i = 0; i < 100; i++) begin
      d = 32'h1000_0000 + 32'(i);
      apply(1'b1, d, 2'(i % 4), 4'hF, 1'b0);
      n_tests++; if (out_valid !== 4'(2 ** (i % 4))) begin n_fail++; $display("FAIL stream_valid[%0d] got=%b exp=%b", i, out_valid, 4'(2 ** (i % 4))); end
      n_tests++; if (out_data !== d) begin n_fail++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, d); end
      n_tests++; if (xfer_cnt !== 16'(start + 32'(i))) begin n_fail++; $display("FAIL stream_cnt[%0d] got=%0d exp=%0d", i, xfer_cnt, start + 32'(i)); end
    end
    apply(1'b0, 32'h0, 2'd0, 4'hF, 1'b0);
    n_tests++; if (xfer_cnt !== 16'(start + 100)) begin n_fail++; $display("FAIL stream_total got=%0d exp=%0d", xfer_cnt, start + 100); end
  endtask

  task automatic test_flush();
    int unsigned c;
    apply(1'b1, 32'hC000_0000, 2'd0, 4'h0, 1'b0);
    apply(1'b1, 32'hC000_0001, 2'd2, 4'h0, 1'b0);
    c = m_cnt;
    apply(1'b1, 32'hC000_0002, 2'd1, 4'h0, 1'b1);
    n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_valid got=%b exp=0000", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    apply(1'b0, 32'h0, 2'd0, 4'hF, 1'b0);
    n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL flush_after_valid got=%b exp=0000", out_valid); end
    n_tests++; if (xfer_cnt !== 16'(c)) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=%0d", xfer_cnt, 16'(c)); end
    n_tests++; if (out_data !== 32'hC000_0000) begin n_fail++; $display("FAIL flush_data_hold got=%h exp=c0000000", out_data); end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      apply(($urandom % 4) != 0, $urandom, 2'($urandom), 4'($urandom), ($urandom % 32) == 0);
      n_tests++;
      if (out_valid !== m_valid() || out_data !== m_last || in_ready !== m_in_ready() ||
          xfer_cnt !== 16'(m_cnt)) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL rand[%0d] got v=%b d=%h r=%b c=%0d exp v=%b d=%h r=%b c=%0d", i,
                   out_valid, out_data, in_ready, xfer_cnt, m_valid(), m_last, m_in_ready(), 16'(m_cnt));
      end
      n_tests++;
      if (out_valid4 !== m_valid() || out_data4 !== m_last || in_ready4 !== m_in_ready() ||
          xfer_cnt4 !== 4'(m_cnt)) begin
        n_fail++;
        if (errs++ < 10)
          $display("FAIL rand4[%0d] got v=%b d=%h r=%b c=%0d exp v=%b d=%h r=%b c=%0d", i,
                   out_valid4, out_data4, in_ready4, xfer_cnt4, m_valid(), m_last, m_in_ready(), 4'(m_cnt));
      end
    end
  endtask

  task automatic test_wrap();
    apply(1'b1, 32'hD000_0000, 2'd1, 4'h0, 1'b0);
    do_reset();
    n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0000", out_valid); end
    release_reset();
    apply(1'b0, 32'h0, 2'd0, 4'hF, 1'b0);
    n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL midrst_after_valid got=%b exp=0000", out_valid); end
    for (int i = 0; i < 17; i++) apply(1'b1, 32'(i), 2'(i), 4'hF, 1'b0);
    apply(1'b0, 32'h0, 2'd0, 4'hF, 1'b0);
    n_tests++; if (xfer_cnt4 !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt4 got=%0d exp=1", xfer_cnt4); end
    n_tests++; if (xfer_cnt !== 16'd17) begin n_fail++; $display("FAIL wrap_cnt16 got=%0d exp=17", xfer_cnt); end
  endtask

  initial begin
    test_reset();
    test_route();
    test_stall();
    test_stream();
    test_flush();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
